mc_ctrl: RTL
============

Name: mc_ctrl

Overview:
- Multi-cycle control FSM that drives the ALU and the multi-cycle datapath of the S_CPU.
- It is the initiator side of the ALU interface: it decodes Op/Funct and issues ALUOp, operand selects and register/memory write enables each cycle.
- The Zero flag returning from the ALU closes the loop for branches.
- Memory accesses use a ready handshake so instruction/data memory may insert wait states.

Parameters:
- PC_INC, 4, constant selected by ALUSrcB=01 for PC increment (documentation only; the datapath implements the constant).

Ports:
- clk  in  1  system clock, rising edge
- rstn  in  1  asynchronous reset, active-low
- Op  in  6  instruction opcode from IR
- Funct  in  6  R-type funct from IR
- Zero  in  1  ALU zero flag
- mem_rdy  in  1  memory access completes this cycle
- PCWrite  out  1  load PC
- IRWrite  out  1  load IR
- IorD  out  1  0=PC address, 1=ALUOut address
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- RegWrite  out  1  register file write
- RegDst  out  1  0=rt, 1=rd
- MemtoReg  out  1  0=ALUOut, 1=MDR
- ALUSrcA  out  2  00=PC, 01=rs, 10=shamt
- ALUSrcB  out  2  00=rt, 01=4, 10=ext imm, 11=sext imm<<2
- EXTOp  out  2  00=sign, 01=zero, 10=imm<<16
- PCSource  out  2  00=ALU result, 01=ALUOut, 10=jump target
- ALUOp  out  4  ALU_* code from ctrl_encode_def.v
- illegal  out  1  one-cycle pulse on unsupported instruction

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, JUMP. Reset state FETCH.
- While rstn=0: all enables 0, selects 0, ALUOp=ALU_NOP, illegal=0. Reset mid-instruction aborts it with no writes.
- Outputs are combinational from state (plus Op/Funct/Zero where noted). Unlisted enables are 0.
- FETCH:
  - Drive MemRead=1, IorD=0, ALUSrcA=00, ALUSrcB=01, ALUOp=ADD, PCSource=00.
  - If mem_rdy=0, stay with IRWrite=PCWrite=0.
  - If mem_rdy=1, assert IRWrite=PCWrite=1 and go to DECODE.
- DECODE:
  - Drive ALUSrcA=00, ALUSrcB=11, ALUOp=ADD (branch target into ALUOut).
  - Next state: lw/sw→MEMADR; R-type or addi/andi/ori/slti/lui→EXEC; beq/bne→BRANCH; j→JUMP.
  - Any other Op, or R-type with unsupported Funct: illegal=1 for this cycle, next state FETCH, no writes.
- MEMADR: ALUSrcA=01, ALUSrcB=10, EXTOp=00, ALUOp=ADD. Next MEMRD (lw) or MEMWR (sw).
- MEMRD: IorD=1, MemRead=1. Hold until mem_rdy, then MEMWB.
- MEMWB: RegWrite=1, RegDst=0, MemtoReg=1. Next FETCH.
- MEMWR: IorD=1, MemWrite=1. Hold until mem_rdy, then FETCH.
- EXEC, R-type, Funct to ALUOp:
  - add 100000→ADD, sub 100010→SUB, and 100100→AND, or 100101→OR.
  - xor 100110→XOR, nor 100111→NOR, slt 101010→SLT, sltu 101011→SLTU.
  - sll 000000→SLL, srl 000010→SRL, sra 000011→SRA.
  - Shifts use ALUSrcA=10; all others ALUSrcA=01. ALUSrcB=00.
- EXEC, I-type: ALUSrcA=01, ALUSrcB=10.
  - addi→ADD/EXTOp00, slti→SLT/00, andi→AND/01, ori→OR/01, lui→LUI/10.
- ALUWB: RegWrite=1, MemtoReg=0, RegDst=1 for R-type, 0 for I-type; EXEC's ALUOp and selects are held in this state. Next FETCH.
- BRANCH:
  - Drive ALUSrcA=01, ALUSrcB=00, ALUOp=SUB, PCSource=01.
  - PCWrite=(beq&Zero)|(bne&~Zero). Next FETCH.
- JUMP: PCWrite=1, PCSource=10. Next FETCH.
- Opcodes: R 000000, j 000010, beq 000100, bne 000101, addi 001000, slti 001010, andi 001100, ori 001101, lui 001111, lw 100011, sw 101011.
- mem_rdy is ignored outside FETCH/MEMRD/MEMWR. A mem_rdy held high gives minimum latency: lw 5 cycles, sw 4, R/I-ALU 4, branch/jump 3.

Optional Feature:
- Macro: MC_CTRL_PERF_EN.
- Defined: adds output instret[31:0], a counter that resets to 0 and increments by 1 on each retiring transition to FETCH. Retiring transitions leave MEMWB, MEMWR (with mem_rdy), ALUWB, BRANCH or JUMP. Illegal exits do not count. Wraps 0xFFFFFFFF→0.
- Undefined: no port and no counter logic.

Test Plan:
- Reset mid-MEMRD (rstn low 1 cycle) → outputs all 0 during reset; FETCH on release; RegWrite never asserted for the aborted lw.
- add (Op 0, Funct 100000), mem_rdy=1 → 4 cycles; ALUOp=ALU_ADD in EXEC/ALUWB; RegWrite=1, RegDst=1 only in cycle 4.
- lw with mem_rdy low 3 cycles in MEMRD → state held 3 extra cycles, then MEMWB with RegWrite=1, MemtoReg=1; total 8 cycles.
- beq Zero=1 → PCWrite=1, PCSource=01 in cycle 3. bne Zero=1 → PCWrite=0.
- sll (Funct 000000) → ALUSrcA=10, ALUOp=ALU_SLL. lui → EXTOp=10, ALUOp=ALU_LUI, RegDst=0.
- Op 111111 → illegal=1 exactly one cycle in DECODE, no enables, back to FETCH. With MC_CTRL_PERF_EN, instret stays unchanged after this and is +1 after each valid instruction.

Source files
------------

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM for the S_CPU datapath: decodes Op/Funct and sequences ALU, memory and
// register-file controls. Optional instruction-retire counter enabled by `define MC_CTRL_PERF_EN.
module mc_ctrl (
    input  logic       clk,
    input  logic       rstn,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       mem_rdy,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] EXTOp,
    output logic [1:0] PCSource,
    output logic [3:0] ALUOp,
    output logic       illegal
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [31:0] instret
`endif
);
    // ALU operation codes shared with the ALU (ctrl_encode_def.v)
    localparam logic [3:0] ALU_NOP  = 4'd0,  ALU_ADD = 4'd1,  ALU_SUB = 4'd2,  ALU_AND = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4,  ALU_XOR = 4'd5,  ALU_NOR = 4'd6,  ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_SLTU = 4'd8,  ALU_SLL = 4'd9,  ALU_SRL = 4'd10, ALU_SRA = 4'd11;
    localparam logic [3:0] ALU_LUI  = 4'd12;

    localparam logic [5:0] OP_R    = 6'b000000, OP_J    = 6'b000010, OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101, OP_ADDI = 6'b001000, OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_ANDI = 6'b001100, OP_ORI  = 6'b001101, OP_LUI  = 6'b001111;
    localparam logic [5:0] OP_LW   = 6'b100011, OP_SW   = 6'b101011;

    typedef enum logic [3:0] {
        StFetch, StDecode, StMemAdr, StMemRd, StMemWb, StMemWr, StExec, StAluWb, StBranch, StJump
    } state_e;

    state_e     r_state, w_next;
    logic       w_r_ok, w_shift, w_i_alu;
    logic [3:0] w_r_aluop, w_i_aluop;
    logic [1:0] w_i_ext;
    logic       w_is_r;

    assign w_is_r = (Op == OP_R);

    always_comb begin
        w_r_ok    = 1'b1;
        w_shift   = 1'b0;
        w_r_aluop = ALU_NOP;
        unique case (Funct)
            6'b100000: w_r_aluop = ALU_ADD;
            6'b100010: w_r_aluop = ALU_SUB;
            6'b100100: w_r_aluop = ALU_AND;
            6'b100101: w_r_aluop = ALU_OR;
            6'b100110: w_r_aluop = ALU_XOR;
            6'b100111: w_r_aluop = ALU_NOR;
            6'b101010: w_r_aluop = ALU_SLT;
            6'b101011: w_r_aluop = ALU_SLTU;
            6'b000000: begin w_r_aluop = ALU_SLL; w_shift = 1'b1; end
            6'b000010: begin w_r_aluop = ALU_SRL; w_shift = 1'b1; end
            6'b000011: begin w_r_aluop = ALU_SRA; w_shift = 1'b1; end
            default:   w_r_ok = 1'b0;
        endcase
    end

    always_comb begin
        w_i_alu   = 1'b1;
        w_i_aluop = ALU_NOP;
        w_i_ext   = 2'b00;
        unique case (Op)
            OP_ADDI: w_i_aluop = ALU_ADD;
            OP_SLTI: w_i_aluop = ALU_SLT;
            OP_ANDI: begin w_i_aluop = ALU_AND; w_i_ext = 2'b01; end
            OP_ORI:  begin w_i_aluop = ALU_OR;  w_i_ext = 2'b01; end
            OP_LUI:  begin w_i_aluop = ALU_LUI; w_i_ext = 2'b10; end
            default: w_i_alu = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= StFetch;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        PCWrite  = 1'b0;
        IRWrite  = 1'b0;
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        RegWrite = 1'b0;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        ALUSrcA  = 2'b00;
        ALUSrcB  = 2'b00;
        EXTOp    = 2'b00;
        PCSource = 2'b00;
        ALUOp    = ALU_NOP;
        illegal  = 1'b0;
        unique case (r_state)
            StFetch: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                ALUOp   = ALU_ADD;
                if (mem_rdy) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    w_next  = StDecode;
                end
            end
            StDecode: begin
                // Speculatively form the branch target in ALUOut.
                ALUSrcB = 2'b11;
                ALUOp   = ALU_ADD;
                if (Op == OP_LW || Op == OP_SW)          w_next = StMemAdr;
                else if ((w_is_r && w_r_ok) || w_i_alu)  w_next = StExec;
                else if (Op == OP_BEQ || Op == OP_BNE)   w_next = StBranch;
                else if (Op == OP_J)                     w_next = StJump;
                else begin
                    illegal = 1'b1;
                    w_next  = StFetch;
                end
            end
            StMemAdr: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                ALUOp   = ALU_ADD;
                w_next  = (Op == OP_SW) ? StMemWr : StMemRd;
            end
            StMemRd: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
                if (mem_rdy) w_next = StMemWb;
            end
            StMemWb: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                w_next   = StFetch;
            end
            StMemWr: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                if (mem_rdy) w_next = StFetch;
            end
            StExec, StAluWb: begin
                // IR is stable, so ALUWB re-decodes to hold EXEC's ALU controls.
                if (w_is_r) begin
                    ALUSrcA = w_shift ? 2'b10 : 2'b01;
                    ALUSrcB = 2'b00;
                    ALUOp   = w_r_aluop;
                end else begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b10;
                    EXTOp   = w_i_ext;
                    ALUOp   = w_i_aluop;
                end
                if (r_state == StAluWb) begin
                    RegWrite = 1'b1;
                    RegDst   = w_is_r;
                    w_next   = StFetch;
                end else begin
                    w_next   = StAluWb;
                end
            end
            StBranch: begin
                ALUSrcA  = 2'b01;
                ALUOp    = ALU_SUB;
                PCSource = 2'b01;
                PCWrite  = ((Op == OP_BEQ) && Zero) || ((Op == OP_BNE) && !Zero);
                w_next   = StFetch;
            end
            StJump: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                w_next   = StFetch;
            end
            default: w_next = StFetch;
        endcase
        if (!rstn) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            IorD     = 1'b0;
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
            RegDst   = 1'b0;
            MemtoReg = 1'b0;
            ALUSrcA  = 2'b00;
            ALUSrcB  = 2'b00;
            EXTOp    = 2'b00;
            PCSource = 2'b00;
            ALUOp    = ALU_NOP;
            illegal  = 1'b0;
        end
    end

`ifdef MC_CTRL_PERF_EN
    logic        w_retire;
    logic [31:0] r_instret;

    assign w_retire = (r_state == StMemWb) || (r_state == StAluWb) || (r_state == StBranch) ||
                      (r_state == StJump)  || ((r_state == StMemWr) && mem_rdy);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)         r_instret <= 32'd0;
        else if (w_retire) r_instret <= r_instret + 32'd1;
    end

    assign instret = r_instret;
`endif

endmodule
